// File: rtl/seq_recurrence_gen.sv
// Second-order integer sequence generator x[n+2] = p*x[n] + q*x[n+1] (Fibonacci/Pell/Jacobsthal),
// streaming one term per accepted handshake with per-term and sticky wrap-around flags.
module seq_recurrence_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0] num_terms,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               a_wr_reg, b_wr_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [1:0]         mode_reg;
    logic               overflow_reg;

    logic               start_acc;
    logic               is_last;
    logic               handshake;
    logic [WIDTH+1:0]   a_ext, b_ext;
    logic [WIDTH+1:0]   next_full;
    logic [WIDTH-1:0]   next_val;
    logic               next_wr;

    assign start_acc = start && (state_reg != ST_RUN);
    assign is_last   = (remaining_reg == CNT_W'(1));
    assign handshake = (state_reg == ST_RUN) && out_ready;

    // Two guard bits are enough: the largest sum is 3*(2^WIDTH-1).
    assign a_ext = {2'b00, a_reg};
    assign b_ext = {2'b00, b_reg};

    always_comb begin
        next_full = a_ext + b_ext;
        case (mode_reg)
            2'b01:   next_full = a_ext + (b_ext << 1);
            2'b10:   next_full = (a_ext << 1) + b_ext;
            default: next_full = a_ext + b_ext;
        endcase
    end

    // Once any operand has wrapped, every later term is wrong too, so the flag propagates.
    assign next_val = next_full[WIDTH-1:0];
    assign next_wr  = (next_full[WIDTH+1:WIDTH] != 2'b00) | a_wr_reg | b_wr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (num_terms != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (handshake && is_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg         <= '0;
            b_reg         <= '0;
            a_wr_reg      <= 1'b0;
            b_wr_reg      <= 1'b0;
            remaining_reg <= '0;
            mode_reg      <= 2'b00;
            overflow_reg  <= 1'b0;
        end else if (start_acc) begin
            a_reg         <= seed0;
            b_reg         <= seed1;
            a_wr_reg      <= 1'b0;
            b_wr_reg      <= 1'b0;
            remaining_reg <= num_terms;
            mode_reg      <= mode;
            overflow_reg  <= 1'b0;
        end else if (handshake) begin
            a_reg         <= b_reg;
            b_reg         <= next_val;
            a_wr_reg      <= b_wr_reg;
            b_wr_reg      <= next_wr;
            remaining_reg <= remaining_reg - CNT_W'(1);
            overflow_reg  <= overflow_reg | a_wr_reg;
        end
    end

    // Outputs are pure decodes of registered state, so they hold while stalled.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_RUN: begin
                out_valid = 1'b1;
                out_data  = a_reg;
                out_ovf   = a_wr_reg;
                out_last  = is_last;
                busy      = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign overflow = overflow_reg;

endmodule
